// File: rtl/secuenciador_estado.sv
// secuenciador_estado: motion-command sequencer feeding the wheel-motor decoder.
// Inserts stop dead-time between motions, runs a refresh watchdog, applies obstacle/e-stop overrides.
module secuenciador_estado #(
  parameter int unsigned DEAD_CYCLES = 50_000,
  parameter int unsigned WDT_CYCLES  = 25_000_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       obstaculo,
  input  logic       parada_emerg,
  output logic [2:0] estado,
  output logic       busy,
  output logic       timeout,
  output logic       obst_block
);

  localparam logic [2:0] MOV_STOP    = 3'b000;
  localparam logic [2:0] MOV_AVANZAR = 3'b001;
  localparam logic [2:0] MOV_MAX     = 3'b100;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD,
    ST_ESTOP
  } state_t;

  state_t           r_state;
  logic [2:0]       r_estado;
  logic [2:0]       r_pending;
  logic             r_ready;
  logic             r_busy;
  logic             r_timeout;
  logic             r_obst_block;
  logic [CNT_W-1:0] r_cnt;
  logic             r_obst_m;
  logic             r_obst_s;
  logic             r_emerg_m;
  logic             r_emerg_s;

  logic             w_accept;
  logic [2:0]       w_cmd;
  logic             w_obst_hit;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_accept   = cmd_valid & r_ready;
  // Undefined codes 101..111 collapse to stop.
  assign w_cmd      = (cmd > MOV_MAX) ? MOV_STOP : cmd;
  assign w_obst_hit = r_obst_s &
                      ((r_estado == MOV_AVANZAR) |
                       ((r_state == ST_DEAD) & (r_pending == MOV_AVANZAR)));
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_estado     <= MOV_STOP;
      r_pending    <= MOV_STOP;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_obst_block <= 1'b0;
      r_cnt        <= '0;
      r_obst_m     <= 1'b0;
      r_obst_s     <= 1'b0;
      r_emerg_m    <= 1'b0;
      r_emerg_s    <= 1'b0;
    end else begin
      r_obst_m  <= obstaculo;
      r_obst_s  <= r_obst_m;
      r_emerg_m <= parada_emerg;
      r_emerg_s <= r_emerg_m;

      if (r_emerg_s) begin
        r_state   <= ST_ESTOP;
        r_estado  <= MOV_STOP;
        r_pending <= MOV_STOP;
        r_ready   <= 1'b0;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
      end else if (r_state == ST_ESTOP) begin
        r_state   <= ST_IDLE;
        r_estado  <= MOV_STOP;
        r_ready   <= 1'b1;
        r_busy    <= 1'b0;
        r_cnt     <= '0;
      end else if (w_obst_hit) begin
        r_state      <= ST_IDLE;
        r_estado     <= MOV_STOP;
        r_pending    <= MOV_STOP;
        r_ready      <= 1'b1;
        r_busy       <= 1'b0;
        r_cnt        <= '0;
        r_obst_block <= 1'b1;
      end else begin
        case (r_state)
          ST_DEAD: begin
            if (r_cnt == DEAD_LAST) begin
              r_state   <= ST_RUN;
              r_estado  <= r_pending;
              r_pending <= MOV_STOP;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
              r_cnt     <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_IDLE, ST_RUN: begin
            r_ready <= 1'b1;
            // Watchdog expiry outranks a command accepted on the same edge.
            if ((r_state == ST_RUN) && (r_cnt == WDT_LAST)) begin
              r_state   <= ST_IDLE;
              r_estado  <= MOV_STOP;
              r_cnt     <= '0;
              r_timeout <= 1'b1;
            end else if (w_accept) begin
              r_timeout <= 1'b0;
              r_cnt     <= '0;
              if (w_cmd != MOV_AVANZAR) begin
                r_obst_block <= 1'b0;
              end
              if ((w_cmd == MOV_AVANZAR) && r_obst_s) begin
                r_state      <= ST_IDLE;
                r_estado     <= MOV_STOP;
                r_obst_block <= 1'b1;
              end else if (w_cmd == MOV_STOP) begin
                r_state  <= ST_IDLE;
                r_estado <= MOV_STOP;
              end else if ((r_state == ST_RUN) && (w_cmd == r_estado)) begin
                r_state <= ST_RUN;
              end else begin
                r_state   <= ST_DEAD;
                r_estado  <= MOV_STOP;
                r_pending <= w_cmd;
                r_ready   <= 1'b0;
                r_busy    <= 1'b1;
              end
            end else if (r_state == ST_RUN) begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign estado     = r_estado;
  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign timeout    = r_timeout;
  assign obst_block = r_obst_block;

endmodule

// File: tb/tb_secuenciador_estado.sv
// tb_secuenciador_estado: directed scenarios plus randomized traffic against a timestamp-based
// reference model of the sequencer (dead-time and watchdog expressed as absolute deadlines).
module tb_secuenciador_estado;

  localparam int unsigned DEAD = 4;
  localparam int unsigned WDT  = 20;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b1;
  logic [2:0] cmd          = 3'd0;
  logic       cmd_valid    = 1'b0;
  logic       obstaculo    = 1'b0;
  logic       parada_emerg = 1'b0;
  logic       cmd_ready;
  logic [2:0] estado;
  logic       busy;
  logic       timeout;
  logic       obst_block;

  int n_tests = 0;
  int n_fail  = 0;

  secuenciador_estado #(
    .DEAD_CYCLES(DEAD),
    .WDT_CYCLES (WDT),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .obstaculo   (obstaculo),
    .parada_emerg(parada_emerg),
    .estado      (estado),
    .busy        (busy),
    .timeout     (timeout),
    .obst_block  (obst_block)
  );

  always #5 clk = ~clk;

  // Reference model: mode flags plus absolute edge-count deadlines.
  int         cyc = 0;
  bit         m_estop, m_dead;
  logic [2:0] m_motion, m_target;
  int         m_dead_until, m_deadline;
  bit         m_o1, m_os, m_e1, m_es;
  logic [2:0] m_estado;
  bit         m_ready, m_busy, m_to, m_ob;

  function automatic void model_reset();
    m_estop = 0; m_dead = 0; m_motion = 3'd0; m_target = 3'd0;
    m_o1 = 0; m_os = 0; m_e1 = 0; m_es = 0;
    m_estado = 3'd0; m_ready = 0; m_busy = 0; m_to = 0; m_ob = 0;
    m_dead_until = 0; m_deadline = 0;
  endfunction

  function automatic void model_edge();
    bit         acc;
    bit         os_now;
    bit         es_now;
    logic [2:0] c;
    acc    = cmd_valid && m_ready;
    c      = (cmd > 3'd4) ? 3'd0 : cmd;
    os_now = m_os;
    es_now = m_es;
    cyc++;
    m_os = m_o1; m_o1 = obstaculo;
    m_es = m_e1; m_e1 = parada_emerg;
    if (es_now) begin
      m_estop = 1; m_dead = 0; m_motion = 3'd0;
    end else if (m_estop) begin
      m_estop = 0;
    end else if (os_now && (m_motion == 3'd1 || (m_dead && m_target == 3'd1))) begin
      m_motion = 3'd0; m_dead = 0; m_ob = 1;
    end else if (m_dead) begin
      if (cyc == m_dead_until) begin
        m_dead = 0; m_motion = m_target; m_deadline = cyc + WDT;
      end
    end else if (m_motion != 3'd0 && cyc == m_deadline) begin
      m_motion = 3'd0; m_to = 1;
    end else if (acc) begin
      m_to = 0;
      if (c != 3'd1) m_ob = 0;
      if (c == 3'd1 && os_now) begin
        m_motion = 3'd0; m_ob = 1;
      end else if (c == 3'd0) begin
        m_motion = 3'd0;
      end else if (c == m_motion) begin
        m_deadline = cyc + WDT;
      end else begin
        m_dead = 1; m_target = c; m_motion = 3'd0; m_dead_until = cyc + DEAD;
      end
    end
    m_ready  = !m_estop && !m_dead;
    m_busy   = m_dead;
    m_estado = m_dead ? 3'd0 : m_motion;
  endfunction

  function automatic logic [6:0] dut_vec();
    return {estado, cmd_ready, busy, timeout, obst_block};
  endfunction

  function automatic logic [6:0] mdl_vec();
    return {m_estado, m_ready, m_busy, m_to, m_ob};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (dut_vec() !== 7'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", dut_vec(), 7'b0);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready);
    end
    step();
    n_tests++;
    if (cmd_ready !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL ready_after_release: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_dead_time();
    cmd = 3'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(DEAD); i++) begin
      n_tests++;
      if (estado !== 3'd0 || busy !== 1'b1 || cmd_ready !== 1'b0 || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL dead_window[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
      step();
    end
    n_tests++;
    if (estado !== 3'd1 || busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL dead_to_run: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_motion_change();
    logic [2:0] prev;
    int         zeros;
    prev = estado; zeros = 0;
    cmd = 3'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (estado === 3'd0) zeros++;
      n_tests++;
      if ((prev === 3'd1 && estado === 3'd2) || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL change_seq[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
      prev = estado;
      step();
    end
    n_tests++;
    if (zeros != int'(DEAD) || estado !== 3'd2) begin
      n_fail++; $display("FAIL change_gap: got zeros=%0d estado=%0d want zeros=%0d estado=2", zeros, estado, DEAD);
    end
  endtask

  task automatic test_watchdog();
    int n;
    cmd = 3'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (DEAD) step();
    n = 0;
    while (estado === 3'd3 && n < 40) begin
      n++;
      step();
    end
    n_tests++;
    if (n != int'(WDT) || estado !== 3'd0 || timeout !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL watchdog: got run=%0d vec=%b want run=%0d vec=%b", n, dut_vec(), WDT, mdl_vec());
    end
    cmd = 3'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (timeout !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL timeout_clear: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_obstacle();
    int n;
    cmd = 3'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (DEAD) step();
    n_tests++;
    if (estado !== 3'd1) begin
      n_fail++; $display("FAIL obst_setup: got estado=%0d want 1", estado);
    end
    obstaculo = 1'b1;
    n = 0;
    while (estado !== 3'd0 && n < 6) begin
      step();
      n++;
    end
    n_tests++;
    if (n < 1 || n > 3 || obst_block !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL obst_stop: got cycles=%0d vec=%b want cycles<=3 vec=%b", n, dut_vec(), mdl_vec());
    end
    cmd = 3'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || obst_block !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL obst_other_accept: got %b want %b", dut_vec(), mdl_vec());
    end
    repeat (DEAD) step();
    n_tests++;
    if (estado !== 3'd4 || obst_block !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL obst_other_run: got %b want %b", dut_vec(), mdl_vec());
    end
    cmd = 3'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (estado !== 3'd0 || obst_block !== 1'b1 || busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL obst_fwd_reject: got %b want %b", dut_vec(), mdl_vec());
    end
    obstaculo = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_estop();
    cmd = 3'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL estop_setup: got busy=%b want 1", busy);
    end
    parada_emerg = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (estado !== 3'd0 || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL estop_hold[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL estop_state: got ready=%b busy=%b want 0 0", cmd_ready, busy);
    end
    parada_emerg = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++;
      if (estado !== 3'd0 || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL estop_release[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL estop_idle: got ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_async_reset();
    cmd = 3'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (DEAD + 2) step();
    n_tests++;
    if (estado !== 3'd4) begin
      n_fail++; $display("FAIL areset_setup: got estado=%0d want 4", estado);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec() !== 7'b0) begin
      n_fail++; $display("FAIL areset_immediate: got %b want %b", dut_vec(), 7'b0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    n_tests++;
    if (cmd_ready !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL areset_release: got %b want %b", dut_vec(), mdl_vec());
    end
    cmd = 3'd7; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(DEAD) + 2; i++) begin
      n_tests++;
      if (estado !== 3'd0 || busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL cmd7_as_stop[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cmd       = 3'($urandom_range(0, 7));
      cmd_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) obstaculo = ~obstaculo;
      if (parada_emerg) begin
        if ($urandom_range(0, 5) == 0) parada_emerg = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        parada_emerg = 1'b1;
      end
      step();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    cmd_valid = 1'b0; obstaculo = 1'b0; parada_emerg = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dead_time();
    test_motion_change();
    test_watchdog();
    test_obstacle();
    test_estop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
